// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for the EX stage: one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [64:0] shifted;
  logic [33:0] trial;
  logic [64:0] work_step;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

`ifdef DIV_SIGNED_EN
  assign neg_a = signed_div_i & opdata1_i[31];
  assign neg_b = signed_div_i & opdata2_i[31];
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div_i;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif

  assign mag_a = neg_a ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag_b = neg_b ? (~opdata2_i + 32'd1) : opdata2_i;

  // Partial remainder lives in work_q[64:32], quotient bits shift into work_q[31:0].
  always_comb begin
    shifted   = work_q << 1;
    trial     = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
    work_step = shifted;
    if (!trial[33]) begin
      work_step = {trial[32:0], shifted[31:1], 1'b1};
    end
  end

  assign quot_fin = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fin  = neg_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFree;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= 64'd0;
      ready_o    <= 1'b0;
    end else begin
      case (state_q)
        StFree: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= StByZero;
            end else begin
              state_q    <= StOn;
              cnt_q      <= 6'd0;
              work_q     <= {33'd0, mag_a};
              divisor_q  <= mag_b;
              neg_quot_q <= neg_a ^ neg_b;
              neg_rem_q  <= neg_a;
            end
          end
        end
        StByZero: begin
          work_q   <= 65'd0;
          result_o <= 64'd0;
          state_q  <= StEnd;
        end
        StOn: begin
          if (annul_i) begin
            state_q <= StFree;
            cnt_q   <= 6'd0;
            ready_o <= 1'b0;
          end else if (cnt_q == 6'd32) begin
            result_o <= {rem_fin, quot_fin};
            ready_o  <= 1'b1;
            state_q  <= StEnd;
            cnt_q    <= 6'd0;
          end else begin
            work_q <= work_step;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        StEnd: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            state_q  <= StFree;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: state_q <= StFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random divides against an arithmetic model.
module tb_div;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (opdata1),
    .opdata2_i   (opdata2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn && SignedEn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full handshake: start held until ready, latency and result checked, then released.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp);
    int n;
    bit got;
    int exp_lat;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    exp_lat    = (b == 32'd0) ? 2 : 33;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      if (ready) got = 1'b1;
      else begin
        n++;
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    check({tag, "_hold_res"}, result, exp);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
    check({tag, "_drop_res"}, result, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    bit          seen;

    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 64'(ready), 64'd0);
    check("reset_res", result, 64'd0);

    // Start presented in the very cycle reset is released.
    rst = 1'b0;
    do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    do_div("byzero", 32'h1234, 32'd0, 1'b0, 64'd0);
    do_div("neg7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
           SignedEn ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'd1, 32'h7FFFFFFC});
    do_div("7_neg2", 32'd7, 32'hFFFFFFFE, 1'b1,
           SignedEn ? {32'd1, 32'hFFFFFFFD} : {32'd7, 32'd0});
    do_div("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
           SignedEn ? {32'd0, 32'h80000000} : {32'h80000000, 32'd0});
    do_div("max_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF});
    do_div("small_big", 32'd5, 32'hFFFFFFFF, 1'b0, {32'd5, 32'd0});

    // Annul at edge 10 of a running divide.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul_rdy", 64'(ready), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check("annul_never_ready", 64'(seen), 64'd0);
    do_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // Reset at edge 20 of a running divide, start still held.
    opdata1 = 32'd12345;
    opdata2 = 32'd6;
    start   = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_on_rdy", 64'(ready), 64'd0);
    check("rst_on_res", result, 64'd0);
    rst = 1'b0;
    do_div("after_rst", 32'd15, 32'd4, 1'b0, {32'd3, 32'd3});

    // Reset while parked in END with start held.
    opdata1 = 32'd77;
    opdata2 = 32'd5;
    start   = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    check("end_rdy", 64'(ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_end_rdy", 64'(ready), 64'd0);
    check("rst_end_res", result, 64'd0);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
      do_div("rand", a, b, sgn, ref_div(a, b, sgn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Reset: rst, synchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU).
REQ-005 opdata1_i  input  32  dividend, supplied by the EX stage from its operand 1.
REQ-006 opdata2_i  input  32  divisor, supplied by the EX stage from its operand 2.
REQ-007 start_i  input  1  divide request; EX holds it high until it has consumed the result.
REQ-008 annul_i  input  1  cancel the in-flight divide (exception or flush).
REQ-009 result_o  output  64  {remainder[63:32] for HI, quotient[31:0] for LO}.
REQ-010 ready_o  output  1  result_o is valid; EX releases its stall request on this.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i=0: next state SHALL be BYZERO.
REQ-013 FREE, start_i=1, annul_i=0, opdata2_i!=0: next state SHALL be ON; step counter cleared to 0; dividend and divisor latched.
REQ-014 FREE, start_i=0 or annul_i=1: the block SHALL remain in FREE with ready_o=0 and result_o=0.
REQ-015 BYZERO: next state SHALL be END with result 64'h0.
REQ-016 ON: each cycle SHALL perform one restoring shift-subtract step on a 65-bit working register (trial = upper 33 bits minus {1'b0,divisor}; non-negative trial replaces the upper bits and shifts in 1, negative trial shifts in 0); counter increments.
REQ-017 ON with counter=32: the block SHALL finalise the result, register it into result_o, assert ready_o, and enter END in the same edge.
REQ-018 Latency: a start sampled at edge 0 SHALL produce ready_o=1 after edge 33 for a nonzero divisor, and after edge 2 for a zero divisor.
REQ-019 annul_i=1 in ON SHALL return the FSM to FREE on the next edge with ready_o=0; no result is produced.
REQ-020 END: ready_o=1 and result_o SHALL stay constant while start_i=1; start_i=0 SHALL return the FSM to FREE with ready_o=0 and result_o=0 on the next edge.
REQ-021 Inputs SHALL be ignored outside FREE; operand changes during ON or END have no effect.
REQ-022 Unsigned mode: quotient = floor(opdata1_i/opdata2_i) and remainder = opdata1_i mod opdata2_i, both 32-bit unsigned.

Reset
REQ-023 rst=1 SHALL force state FREE, counter=0, working register=0, result_o=64'h0, and ready_o=0 on the next edge, overriding every other input including a divide in ON or END.
REQ-024 After rst deasserts, the first start_i SHALL be accepted under REQ-012/013 with no extra idle cycle.

Configuration
REQ-025 Macro DIV_SIGNED_EN defined: signed_div_i=1 SHALL take two's-complement magnitudes of negative operands at start, negate the quotient when the operand signs differ, and give the remainder the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-026 Macro DIV_SIGNED_EN undefined: signed_div_i SHALL be ignored and every divide SHALL be unsigned; the latency of REQ-018 is unchanged.

Verification
REQ-027 Unsigned 100 / 7 (start held) -> ready_o rises after edge 33 and result_o = {32'd2, 32'd14}; start_i dropped -> ready_o=0 and result_o=0 the next cycle.
REQ-028 DIV_SIGNED_EN, signed -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; 7 / -2 -> {32'd1, 32'hFFFFFFFD}.
REQ-029 Divide 0x1234 / 0 -> BYZERO then END; ready_o=1 after edge 2 with result_o = 64'h0.
REQ-030 Start 1000 / 3, annul_i pulsed at cycle 10 -> FREE next edge and ready_o never asserts; a following 9 / 3 returns {0, 3} at normal latency.
REQ-031 rst asserted at cycle 20 of an ON divide -> FREE, ready_o=0, result_o=0 next edge; a fresh 15 / 4 then returns {3, 3}.
REQ-032 DIV_SIGNED_EN undefined, signed_div_i=1, 0xFFFFFFF9 / 2 -> result_o = {32'd1, 32'h7FFFFFFC}.
